// File: rtl/green_weight_gen.sv
// rtl/green_weight_gen.sv - gradient-ratio blend weights w_s/w_f via 9-step restoring divide; option macro GREEN_WEIGHT_ROUND_EN
module green_weight_gen #(
  parameter int pixelBitWidth  = 12,
  parameter int weightBitWidth = 8,
  parameter int gradBitWidth   = 14
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [gradBitWidth-1:0]         grad_s,
  input  logic [gradBitWidth-1:0]         grad_f,
  input  logic signed [pixelBitWidth:0]   green_s_in,
  input  logic signed [pixelBitWidth:0]   green_f_in,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [weightBitWidth-1:0]       w_s,
  output logic [weightBitWidth-1:0]       w_f,
  output logic signed [pixelBitWidth:0]   green_s,
  output logic signed [pixelBitWidth:0]   green_f
);

  localparam int WW = weightBitWidth;
  localparam int QW = WW + 1;            // quotient spans 0..2^WW inclusive
  localparam int DW = gradBitWidth + 1;  // grad_s+grad_f never overflows
  localparam int CW = $clog2(QW);
`ifdef GREEN_WEIGHT_ROUND_EN
  localparam int NW = gradBitWidth + WW + 1;
`else
  localparam int NW = gradBitWidth + WW;
`endif
  localparam logic [QW-1:0] ONE_Q   = {1'b1, {WW{1'b0}}};
  localparam logic [WW-1:0] HALF_W  = {1'b1, {(WW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DIV, OUT} state_t;

  state_t          r_state, w_state_next;
  logic [DW-1:0]   r_den;
  logic [DW-1:0]   r_rem;
  logic [QW-1:0]   r_nlo;
  logic [QW-2:0]   r_q;
  logic [CW-1:0]   r_cnt;

  logic [DW-1:0]   w_den;
  logic [NW-1:0]   w_num;
  logic [DW:0]     w_trial;
  logic [DW:0]     w_diff;
  logic            w_ge;
  logic [DW-1:0]   w_rem_next;
  logic [QW-1:0]   w_q_next;
  logic [QW-1:0]   w_inv;
  logic [WW-1:0]   w_ws_sat;
  logic [WW-1:0]   w_wf_sat;

  assign w_den = DW'(grad_s) + DW'(grad_f);
`ifdef GREEN_WEIGHT_ROUND_EN
  assign w_num = (NW'(grad_f) << WW) + NW'(w_den >> 1);
`else
  assign w_num = NW'(grad_f) << WW;
`endif

  // Only the low QW numerator bits are shifted in; the bits above them seed the
  // remainder, which is always below den because the quotient fits in QW bits.
  assign w_trial    = {r_rem, r_nlo[QW-1]};
  assign w_diff     = w_trial - {1'b0, r_den};
  assign w_ge       = ~w_diff[DW];
  assign w_rem_next = w_ge ? w_diff[DW-1:0] : w_trial[DW-1:0];
  assign w_q_next   = {r_q, w_ge};

  // Saturate 256 down to 255 for both complementary weights
  assign w_inv    = ONE_Q - w_q_next;
  assign w_ws_sat = w_q_next[QW-1] ? {WW{1'b1}} : w_q_next[WW-1:0];
  assign w_wf_sat = w_inv[QW-1]    ? {WW{1'b1}} : w_inv[WW-1:0];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic and ready output
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = (w_den == '0) ? OUT : DIV;
      end
      DIV:     if (r_cnt == '0) w_state_next = OUT;
      OUT:     if (out_ready)   w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, one divide step per cycle, output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_den     <= '0;
      r_rem     <= '0;
      r_nlo     <= '0;
      r_q       <= '0;
      r_cnt     <= '0;
      out_valid <= 1'b0;
      w_s       <= '0;
      w_f       <= '0;
      green_s   <= '0;
      green_f   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            green_s <= green_s_in;
            green_f <= green_f_in;
            r_den   <= w_den;
            r_rem   <= DW'(w_num[NW-1:QW]);
            r_nlo   <= w_num[QW-1:0];
            r_q     <= '0;
            r_cnt   <= CW'(WW);
            if (w_den == '0) begin
              w_s       <= HALF_W;
              w_f       <= HALF_W;
              out_valid <= 1'b1;
            end
          end
        end
        DIV: begin
          r_rem <= w_rem_next;
          r_nlo <= r_nlo << 1;
          r_q   <= w_q_next[QW-2:0];
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            w_s       <= w_ws_sat;
            w_f       <= w_wf_sat;
            out_valid <= 1'b1;
          end
        end
        OUT: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_green_weight_gen.sv
// tb/tb_green_weight_gen.sv - scoreboard bench for green_weight_gen
module tb_green_weight_gen;

  localparam int PW = 12;
  localparam int WW = 8;
  localparam int GW = 14;
`ifdef GREEN_WEIGHT_ROUND_EN
  localparam int WS12 = 171;
  localparam int WF12 = 85;
`else
  localparam int WS12 = 170;
  localparam int WF12 = 86;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic in_ready, out_valid;
  logic [GW-1:0] grad_s = '0, grad_f = '0;
  logic signed [PW:0] green_s_in = '0, green_f_in = '0;
  logic signed [PW:0] green_s, green_f;
  logic [WW-1:0] w_s, w_f;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [WW-1:0] ws;
    logic [WW-1:0] wf;
    logic [PW:0]   gs;
    logic [PW:0]   gf;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  green_weight_gen #(.pixelBitWidth(PW), .weightBitWidth(WW), .gradBitWidth(GW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .grad_s(grad_s), .grad_f(grad_f),
    .green_s_in(green_s_in), .green_f_in(green_f_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .w_s(w_s), .w_f(w_f),
    .green_s(green_s), .green_f(green_f)
  );

  function automatic exp_t model(input int gs, input int gf, input int ngs, input int ngf);
    exp_t e;
    int den, q;
    den = gs + gf;
    if (den == 0) begin
      e.ws = WW'(128);
      e.wf = WW'(128);
    end else begin
`ifdef GREEN_WEIGHT_ROUND_EN
      q = (256 * gf + den / 2) / den;
`else
      q = (256 * gf) / den;
`endif
      e.ws = (q > 255) ? WW'(255) : WW'(q);
      e.wf = ((256 - q) > 255) ? WW'(255) : WW'(256 - q);
    end
    e.gs = (PW+1)'(ngs);
    e.gf = (PW+1)'(ngf);
    return e;
  endfunction

  function automatic exp_t mk(input int ws, input int wf, input int ngs, input int ngf);
    exp_t e;
    e.ws = WW'(ws);
    e.wf = WW'(wf);
    e.gs = (PW+1)'(ngs);
    e.gf = (PW+1)'(ngf);
    return e;
  endfunction

  // Waits for in_ready at a falling edge, presents one sample for one cycle.
  // Returns at the falling edge of cycle 1 (accept happened in cycle 0).
  task automatic send(input int gs, input int gf, input int ngs, input int ngf);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_ready: in_ready=%0b required 1", in_ready);
    end
    grad_s = GW'(gs);
    grad_f = GW'(gf);
    green_s_in = (PW+1)'(ngs);
    green_f_in = (PW+1)'(ngf);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, w_s, w_f, green_s, green_f} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%0b ws=%0d wf=%0d gs=%0d gf=%0d required all 0",
               out_valid, w_s, w_f, green_s, green_f);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %0b required 1", in_ready);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_spec_cases();
    int t_gs[6]  = '{100, 300, 0, 0,    50,    1};
    int t_gf[6]  = '{100, 100, 0, 50,   0,     2};
    int t_ngs[6] = '{500, 7,   -1, 4095, -4096, 0};
    int t_ngf[6] = '{-20, -7,  1, 0,    100,   -1};
    int t_ws[6]  = '{128, 64,  128, 255, 0,    WS12};
    int t_wf[6]  = '{128, 192, 128, 0,   255,  WF12};
    int t_lat[6] = '{10,  10,  1,   10,  10,   10};
    int lat;
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      sb.push_back(mk(t_ws[i], t_wf[i], t_ngs[i], t_ngf[i]));
      send(t_gs[i], t_gf[i], t_ngs[i], t_ngf[i]);
      wait_out(lat);
      checks++;
      if (!out_valid || lat != t_lat[i]) begin
        errors++;
        $display("FAIL spec_latency[%0d]: got valid=%0b at cycle %0d required valid=1 at cycle %0d",
                 i, out_valid, lat, t_lat[i]);
      end
      e = sb.pop_front();
      checks++;
      if ({w_s, w_f, green_s, green_f} !== e) begin
        errors++;
        $display("FAIL spec_value[%0d]: got ws=%0d wf=%0d gs=%0d gf=%0d required ws=%0d wf=%0d gs=%0d gf=%0d",
                 i, w_s, w_f, green_s, green_f, e.ws, e.wf, $signed(e.gs), $signed(e.gf));
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL spec_release[%0d]: got valid=%0b in_ready=%0b required 0/1", i, out_valid, in_ready);
      end
    end
  endtask

  // Back-to-back random samples; in_valid stays high with junk while busy
  task automatic test_back_to_back();
    int gs, gf, ngs, ngf, n;
    bit busy_bad;
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      gs  = (i % 3 == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 16383));
      gf  = (i % 4 == 1) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 16383));
      ngs = int'($urandom_range(0, 8191)) - 4096;
      ngf = int'($urandom_range(0, 8191)) - 4096;
      sb.push_back(model(gs, gf, ngs, ngf));
      send(gs, gf, ngs, ngf);
      busy_bad = 1'b0;
      n = 0;
      grad_s = GW'($urandom);
      grad_f = GW'($urandom);
      green_s_in = (PW+1)'($urandom);
      in_valid = 1'b1;
      while (!out_valid && n < 40) begin
        if (in_ready !== 1'b0) busy_bad = 1'b1;
        @(negedge clk);
        n++;
      end
      in_valid = 1'b0;
      checks++;
      if (busy_bad || !out_valid) begin
        errors++;
        $display("FAIL busy_ready[%0d]: in_ready rose while busy=%0b valid=%0b required 0/1", i, busy_bad, out_valid);
      end
      e = sb.pop_front();
      checks++;
      if ({w_s, w_f, green_s, green_f} !== e) begin
        errors++;
        $display("FAIL random_value[%0d] (%0d,%0d): got ws=%0d wf=%0d gs=%0d gf=%0d required ws=%0d wf=%0d gs=%0d gf=%0d",
                 i, gs, gf, w_s, w_f, green_s, green_f, e.ws, e.wf, $signed(e.gs), $signed(e.gf));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure_reset();
    int lat;
    exp_t e;
    out_ready = 1'b0;
    sb.push_back(mk(64, 192, 7, -7));
    send(300, 100, 7, -7);
    wait_out(lat);
    e = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({out_valid, in_ready, w_s, w_f, green_s, green_f} !== {2'b10, e}) begin
        errors++;
        $display("FAIL hold[%0d]: got v=%0b rdy=%0b ws=%0d wf=%0d gs=%0d gf=%0d required v=1 rdy=0 ws=%0d wf=%0d",
                 i, out_valid, in_ready, w_s, w_f, green_s, green_f, e.ws, e.wf);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || {w_s, w_f} !== {e.ws, e.wf}) begin
      errors++;
      $display("FAIL hold_release: got v=%0b rdy=%0b ws=%0d wf=%0d required 0/1 ws=%0d wf=%0d",
               out_valid, in_ready, w_s, w_f, e.ws, e.wf);
    end
    send(1000, 20, 300, -300);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, w_s, w_f, green_s, green_f} !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: got v=%0b ws=%0d wf=%0d gs=%0d gf=%0d rdy=%0b required all 0, rdy=1",
               out_valid, w_s, w_f, green_s, green_f, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_reset: got rdy=%0b v=%0b required 1/0", in_ready, out_valid);
    end
    lat = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) lat++;
    end
    checks++;
    if (lat != 0) begin
      errors++;
      $display("FAIL discarded: got out_valid for %0d cycles required 0", lat);
    end
    sb.push_back(mk(0, 255, 9, 9));
    send(50, 0, 9, 9);
    wait_out(lat);
    e = sb.pop_front();
    checks++;
    if (!out_valid || lat != 10 || {w_s, w_f, green_s, green_f} !== e) begin
      errors++;
      $display("FAIL recover: got v=%0b lat=%0d ws=%0d wf=%0d required v=1 lat=10 ws=%0d wf=%0d",
               out_valid, lat, w_s, w_f, e.ws, e.wf);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_spec_cases();
    test_back_to_back();
    test_backpressure_reset();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
